// File: rtl/nios2_pio_edge_in.sv
// nios2_pio_edge_in: Avalon-MM PIO input port with synchronised inputs, edge capture and masked level interrupt.
module nios2_pio_edge_in #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int BIT_CLEAR   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] data, prev_q, irqmask_q, irqmask_d, edgecap_q, edgecap_d, edge_det, clr, rd_sel;
    logic [31:0] readdata_q, readdata_d;
    logic wr;
    logic unused_wd;

    assign data      = sync_q[SYNC_STAGES-1];
    assign wr        = chipselect & ~write_n;
    assign unused_wd = &{1'b0, writedata};
    assign readdata  = readdata_q;
    assign irq       = |(edgecap_q & irqmask_q);

    always_comb begin
        edge_det   = EDGE_TYPE == 0 ? data & ~prev_q : EDGE_TYPE == 1 ? ~data & prev_q : data ^ prev_q;
        clr        = (wr && address == 2'd3) ? (BIT_CLEAR != 0 ? writedata[WIDTH-1:0] : '1) : '0;
        // a fresh edge wins over a simultaneous clear of the same bit
        edgecap_d  = (edgecap_q & ~clr) | edge_det;
        irqmask_d  = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : irqmask_q;
        rd_sel     = address == 2'd0 ? data : address == 2'd2 ? irqmask_q : address == 2'd3 ? edgecap_q : '0;
        readdata_d = 32'(rd_sel);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q     <= data;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end
endmodule

// File: doc/nios2_pio_edge_in.md
NIOS2_PIO_EDGE_IN -- requirements
Module: nios2_pio_edge_in

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, input port width, legal range 1..32.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, input synchroniser depth, legal range 2..3.
REQ-003 SHALL provide parameter EDGE_TYPE, default 0, capture mode: 0 rising, 1 falling, 2 any edge.
REQ-004 SHALL provide parameter BIT_CLEAR, default 1: 1 = write-1-to-clear per bit; 0 = any write to the edge register clears all bits.
REQ-005 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL provide port address  input  2  Avalon slave word address.
REQ-008 SHALL provide port chipselect  input  1  slave select, qualifies writes.
REQ-009 SHALL provide port write_n  input  1  active-low write strobe.
REQ-010 SHALL provide port writedata  input  32  write data.
REQ-011 SHALL provide port in_port  input  WIDTH  asynchronous external inputs.
REQ-012 SHALL provide port readdata  output  32  registered read data.
REQ-013 SHALL provide port irq  output  1  level interrupt request, active-high.

Function
REQ-014 SHALL synchronise in_port through SYNC_STAGES flops per bit; sync output is "data".
REQ-015 SHALL hold a WIDTH-bit prev register loaded with data every cycle.
REQ-016 SHALL compute per-bit edge: rising = data & ~prev; falling = ~data & prev; any = data ^ prev, selected by EDGE_TYPE.
REQ-017 SHALL define write strobe wr = chipselect & ~write_n; the port has no read strobe and no wait states.
REQ-018 SHALL map registers: addr 0 data (RO); addr 1 reserved (reads 0, writes ignored); addr 2 irqmask (RW); addr 3 edgecapture (read; write clears).
REQ-019 SHALL update readdata on every clock from the address-selected register: read latency exactly 1 cycle; bits 31..WIDTH read 0.
REQ-020 SHALL load irqmask with writedata[WIDTH-1:0] on wr at addr 2.
REQ-021 SHALL set edgecapture bit i on the clock after edge[i] is detected and keep it set until cleared.
REQ-022 SHALL, on wr at addr 3 with BIT_CLEAR=1, clear exactly the bits where writedata[i]=1; with BIT_CLEAR=0, clear all bits.
REQ-023 SHALL give set priority over clear when edge[i] and a clear of bit i occur in the same cycle; the bit stays 1.
REQ-024 SHALL drive irq = OR over (edgecapture & irqmask), combinationally from registered state.
REQ-025 SHALL give latency: in_port change sampled at edge k -> data valid after edge k+SYNC_STAGES-1 -> readdata(addr 0) and edgecapture updated at edge k+SYNC_STAGES -> edgecapture visible on readdata at edge k+SYNC_STAGES+1.
REQ-026 SHALL ignore writes to addr 0 and 1; writes with chipselect=0 have no effect.
REQ-027 SHALL treat pulses shorter than one clk period as not guaranteed to be captured.

Reset
REQ-028 SHALL, while reset_n=0, asynchronously clear the synchroniser, prev, irqmask, edgecapture and readdata to 0; irq=0.
REQ-029 SHALL, after reset release with in_port held high and EDGE_TYPE 0 or 2, capture one rising edge on every bit, because prev resets to 0.
REQ-030 SHALL discard in-flight edges and pending interrupts when reset asserts mid-operation; there is no stored state across reset.

Verification
REQ-031 SHALL cover reset: assert reset_n=0 with random state -> readdata=0x0, irq=0 immediately, before any clk edge.
REQ-032 SHALL cover latency: WIDTH=8, SYNC_STAGES=2, address=0, in_port 0x00->0xA5 before edge k -> readdata=0x000000A5 after edge k+2, not earlier.
REQ-033 SHALL cover capture and irq: EDGE_TYPE=0, irqmask=0x01, in_port bit0 0->1 -> edgecapture=0x01 and irq=1 at edge k+2; in_port bit1 rises with mask bit1=0 -> edgecapture=0x03, irq unchanged.
REQ-034 SHALL cover clear: BIT_CLEAR=1, edgecapture=0x03, write 0x01 to addr 3 -> edgecapture=0x02, irq=0; with BIT_CLEAR=0 same write -> edgecapture=0x00.
REQ-035 SHALL cover collision: write 0xFF to addr 3 in the same cycle bit2 edge is detected -> edgecapture=0x04 afterwards.
REQ-036 SHALL cover modes: EDGE_TYPE=1 pulse 0->1->0 on bit3 -> only the falling edge sets 0x08; EDGE_TYPE=2 -> both edges set the bit; reserved addr 1 reads 0x0.
